// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: states, opcodes,
// ALU field encodings and the bundled strobe record.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       branch;
  } ctrl_t;

  // States that sit on the memory handshake and are subject to the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/cu_out_decode.sv
// Combinational state -> datapath strobe decode. Everything is Moore except the
// FETCH PC/IR loads, which wait for the memory to deliver the instruction.
module cu_out_decode
  import cu_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   reset,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_write  = mem_ready;
          ctrl.ir_write  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_EXEC_R: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_RFUNCT;
        end
        S_EXEC_I: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_IFUNCT;
        end
        S_MEM_ADDR: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.iord     = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.iord      = 1'b1;
        end
        S_WB_ALU: ctrl.reg_write = 1'b1;
        S_WB_MEM: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_REG;
          ctrl.alu_op    = ALUOP_SUB;
          ctrl.branch    = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences each instruction, waits on the memory
// handshake, traps on illegal opcodes / memory timeouts, counts retirements.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         Opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               Branch,
  output logic               illegal,
  output logic               bus_err,
  output logic [COUNT_W-1:0] instret
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

  state_t             state_reg, state_next;
  logic [WAIT_W-1:0]  wait_reg;
  logic [COUNT_W-1:0] instret_reg;
  logic               illegal_reg, bus_err_reg;
  logic               retire, illegal_set, timeout_hit, waiting;
  ctrl_t              ctrl;

  always_comb begin
    state_next  = state_reg;
    retire      = 1'b0;
    illegal_set = 1'b0;
    waiting     = is_wait_state(state_reg) && !mem_ready;
    timeout_hit = (TIMEOUT > 0) && waiting && (wait_reg == WAIT_LIMIT);
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          default: begin
            state_next  = S_TRAP;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
      S_MEM_ADDR: state_next = (Opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_next = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default: state_next = S_TRAP;
    endcase
    // timeout_hit implies mem_ready=0, so it can never collide with a retire
    if (timeout_hit) state_next = S_TRAP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      wait_reg    <= '0;
      instret_reg <= '0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (TIMEOUT == 0 || !waiting || state_next != state_reg)
        wait_reg <= '0;
      else
        wait_reg <= wait_reg + WAIT_W'(1);
      if (retire)      instret_reg <= instret_reg + COUNT_W'(1);
      if (illegal_set) illegal_reg <= 1'b1;
      if (timeout_hit) bus_err_reg <= 1'b1;
    end
  end

  cu_out_decode u_out_decode (
    .state     (state_reg),
    .mem_ready (mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  assign PCWrite  = ctrl.pc_write;
  assign IRWrite  = ctrl.ir_write;
  assign IorD     = ctrl.iord;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign Branch   = ctrl.branch;
  assign illegal  = illegal_reg;
  assign bus_err  = bus_err_reg;
  assign instret  = instret_reg;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed per-cycle vector bench for multicycle_control_unit (TIMEOUT=4, COUNT_W=2).
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA, Branch;
  logic [1:0] ALUSrcB, ALUOp;
  logic       illegal, bus_err;
  logic [1:0] instret;

  always #5 clk = ~clk;

  multicycle_control_unit #(.TIMEOUT(4), .COUNT_W(2)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Branch(Branch),
    .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  // {PCWrite,IRWrite,IorD,MemRead,MemWrite,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,Branch}
  localparam logic [12:0] ZERO   = 13'b0;
  localparam logic [12:0] F_WAIT = 13'b0_0_0_1_0_0_0_0_01_00_0;
  localparam logic [12:0] F_GO   = 13'b1_1_0_1_0_0_0_0_01_00_0;
  localparam logic [12:0] DEC    = 13'b0_0_0_0_0_0_0_0_10_00_0;
  localparam logic [12:0] EXR    = 13'b0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [12:0] EXI    = 13'b0_0_0_0_0_0_0_1_10_11_0;
  localparam logic [12:0] MADR   = 13'b0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [12:0] MRD    = 13'b0_0_1_1_0_0_0_0_00_00_0;
  localparam logic [12:0] MWR    = 13'b0_0_1_0_1_0_0_0_00_00_0;
  localparam logic [12:0] WBA    = 13'b0_0_0_0_0_0_1_0_00_00_0;
  localparam logic [12:0] WBM    = 13'b0_0_0_0_0_1_1_0_00_00_0;
  localparam logic [12:0] BR     = 13'b0_0_0_0_0_0_0_1_00_01_1;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BQ = 7'b1100011, ILL = 7'b1000010;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    logic [12:0] ctrl;
    logic        ill;
    logic        berr;
    logic [1:0]  ir;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic add(input logic rst, input logic [6:0] op, input logic rdy,
                     input logic [12:0] ctrl, input logic ill, input logic berr,
                     input logic [1:0] ir);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.ctrl = ctrl;
    v.ill = ill; v.berr = berr; v.ir = ir;
    vecs.push_back(v);
  endtask

  // One vector = one clock cycle: drive after the falling edge, sample before the rising edge.
  task automatic apply(input string name, input vec_t v);
    logic [16:0] got, exp;
    @(negedge clk);
    reset = v.rst; Opcode = v.op; mem_ready = v.rdy;
    #1;
    got = {PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUOp, Branch, illegal, bus_err, instret};
    exp = {v.ctrl, v.ill, v.berr, v.ir};
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got ctrl=%b ill=%b berr=%b instret=%0d, want ctrl=%b ill=%b berr=%b instret=%0d",
               name, got[16:4], got[3], got[2], got[1:0], v.ctrl, v.ill, v.berr, v.ir);
    end else begin
      $display("ok   %s: ctrl=%b ill=%b berr=%b instret=%0d", name, got[16:4], got[3], got[2], got[1:0]);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; Opcode = 7'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    add(1, R, 1, ZERO, 0, 0, 0);
    // R-type, zero wait
    add(0, R, 1, F_GO, 0, 0, 0); add(0, R, 1, DEC, 0, 0, 0);
    add(0, R, 1, EXR, 0, 0, 0);  add(0, R, 1, WBA, 0, 0, 0);
    // I-type
    add(0, I, 1, F_GO, 0, 0, 1); add(0, I, 1, DEC, 0, 0, 1);
    add(0, I, 1, EXI, 0, 0, 1);  add(0, I, 1, WBA, 0, 0, 1);
    // load, three wait cycles; ready arrives exactly at the timeout limit
    add(0, LD, 1, F_GO, 0, 0, 2); add(0, LD, 1, DEC, 0, 0, 2); add(0, LD, 1, MADR, 0, 0, 2);
    add(0, LD, 0, MRD, 0, 0, 2);  add(0, LD, 0, MRD, 0, 0, 2); add(0, LD, 0, MRD, 0, 0, 2);
    add(0, LD, 1, MRD, 0, 0, 2);  add(0, LD, 1, WBM, 0, 0, 2);
    // store then branch; the counter wraps 3 -> 0 -> 1
    add(0, ST, 1, F_GO, 0, 0, 3); add(0, ST, 1, DEC, 0, 0, 3);
    add(0, ST, 1, MADR, 0, 0, 3); add(0, ST, 1, MWR, 0, 0, 3);
    add(0, BQ, 1, F_GO, 0, 0, 0); add(0, BQ, 1, DEC, 0, 0, 0); add(0, BQ, 1, BR, 0, 0, 0);
    // fetch stalls to the limit, ready wins
    add(0, R, 0, F_WAIT, 0, 0, 1); add(0, R, 0, F_WAIT, 0, 0, 1); add(0, R, 0, F_WAIT, 0, 0, 1);
    add(0, R, 1, F_GO, 0, 0, 1);   add(0, R, 1, DEC, 0, 0, 1);
    add(0, R, 1, EXR, 0, 0, 1);    add(0, R, 1, WBA, 0, 0, 1);
    // store times out in MEM_WR: no retire
    add(0, ST, 1, F_GO, 0, 0, 2); add(0, ST, 1, DEC, 0, 0, 2); add(0, ST, 1, MADR, 0, 0, 2);
    add(0, ST, 0, MWR, 0, 0, 2);  add(0, ST, 0, MWR, 0, 0, 2);
    add(0, ST, 0, MWR, 0, 0, 2);  add(0, ST, 0, MWR, 0, 0, 2);
    add(0, ST, 1, ZERO, 0, 1, 2); add(0, ST, 1, ZERO, 0, 1, 2);
    add(1, ST, 1, ZERO, 0, 1, 2);
    // fetch timeout after 4 cycles
    add(0, R, 0, F_WAIT, 0, 0, 0); add(0, R, 0, F_WAIT, 0, 0, 0);
    add(0, R, 0, F_WAIT, 0, 0, 0); add(0, R, 0, F_WAIT, 0, 0, 0);
    add(0, R, 0, ZERO, 0, 1, 0);
    add(1, R, 1, ZERO, 0, 1, 0);
    // illegal opcode: absorbing trap for 10 cycles, then reset
    add(0, ILL, 1, F_GO, 0, 0, 0); add(0, ILL, 1, DEC, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(0, (k % 3 == 0) ? R : ILL, logic'(k % 2), ZERO, 1, 0, 0);
    add(1, R, 1, ZERO, 1, 0, 0);
    // reset while MEM_RD: no retire, PCWrite gated during reset
    add(0, LD, 1, F_GO, 0, 0, 0); add(0, LD, 1, DEC, 0, 0, 0); add(0, LD, 1, MADR, 0, 0, 0);
    add(0, LD, 0, MRD, 0, 0, 0);  add(1, LD, 1, ZERO, 0, 0, 0); add(0, LD, 1, F_GO, 0, 0, 0);

    foreach (vecs[n]) apply($sformatf("vec%0d", n), vecs[n]);

    // Hand sequence: reset dominates an illegal opcode sitting in DECODE.
    v = '{rst: 1, op: ILL, rdy: 1, ctrl: ZERO, ill: 0, berr: 0, ir: 0};
    apply("rst_in_decode_pre", v);
    v = '{rst: 0, op: ILL, rdy: 1, ctrl: F_GO, ill: 0, berr: 0, ir: 0};
    apply("ill_fetch", v);
    v = '{rst: 1, op: ILL, rdy: 1, ctrl: ZERO, ill: 0, berr: 0, ir: 0};
    apply("rst_in_decode", v);
    v = '{rst: 0, op: ILL, rdy: 0, ctrl: F_WAIT, ill: 0, berr: 0, ir: 0};
    apply("after_rst_decode", v);

    // Hand sequence: six back-to-back 3-cycle branches, counter wraps mod 4.
    v = '{rst: 1, op: BQ, rdy: 1, ctrl: ZERO, ill: 0, berr: 0, ir: 0};
    apply("br_loop_reset", v);
    for (int k = 0; k < 6; k++) begin
      v = '{rst: 0, op: BQ, rdy: 1, ctrl: F_GO, ill: 0, berr: 0, ir: 2'(k)};
      apply($sformatf("br%0d_fetch", k), v);
      v.ctrl = DEC; apply($sformatf("br%0d_decode", k), v);
      v.ctrl = BR;  apply($sformatf("br%0d_branch", k), v);
    end
    v = '{rst: 0, op: BQ, rdy: 0, ctrl: F_WAIT, ill: 0, berr: 0, ir: 2};
    apply("br_loop_final", v);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
